// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
// datapath_pkg : shared functional-unit status table types and constants
// Revision 1.0
// ============================================================================
package datapath_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    WAIT   = 2'd1,
    READY  = 2'd2,
    ISSUED = 2'd3
  } fust_state_t;

  localparam int FUST_TAG_W = 2;
  localparam int FUST_ROW_W = 32;

  typedef logic [FUST_TAG_W-1:0] fust_tag_t;

  typedef struct packed {
    logic [FUST_ROW_W-1:0] payload;
    fust_tag_t             t1;
    fust_tag_t             t2;
    fust_tag_t             t3;
  } fust_row_t;

  localparam fust_tag_t TAG_NONE = '0;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : round-robin pick of the first request at or above ptr (wrapping)
// Revision 1.0
// ============================================================================
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] pos;
  logic             hit;

  // N is a power of two, so the IDX_W-bit add wraps for free
  always_comb begin
    grant = '0;
    idx   = '0;
    hit   = 1'b0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      pos = ptr + IDX_W'(i);
      if (!hit && req[pos]) begin
        hit        = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

  assign valid = hit;

endmodule
`default_nettype wire

// File: rtl/fust_bank.sv
`default_nettype none
// ============================================================================
// fust_bank : multi-row functional-unit status table with round-robin issue
// Revision 1.0
// ============================================================================
module fust_bank
  import datapath_pkg::*;
#(
  parameter int  NUM_ROWS = 4,
  parameter int  TAG_W    = FUST_TAG_W,
  parameter int  ROW_W    = FUST_ROW_W,
  localparam int IDX_W    = $clog2(NUM_ROWS)
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                dispatch_en,
  input  logic [ROW_W-1:0]    dispatch_row,
  input  logic [TAG_W-1:0]    dispatch_t1,
  input  logic [TAG_W-1:0]    dispatch_t2,
  input  logic [TAG_W-1:0]    dispatch_t3,
  output logic                full,
  output logic [IDX_W-1:0]    alloc_idx,
  input  logic                wb_valid,
  input  logic [TAG_W-1:0]    wb_tag,
  output logic                issue_valid,
  input  logic                issue_ready,
  output logic [IDX_W-1:0]    issue_idx,
  output logic [ROW_W-1:0]    issue_row,
  input  logic                done_en,
  input  logic [IDX_W-1:0]    done_idx,
  output logic [NUM_ROWS-1:0] busy_vec,
  output logic [NUM_ROWS-1:0] ready_vec,
  output logic [IDX_W:0]      occupancy
);

  localparam int CNT_W = IDX_W + 1;

  typedef logic [TAG_W-1:0] tag_t;
  typedef struct packed {
    logic [ROW_W-1:0] payload;
    tag_t             t1;
    tag_t             t2;
    tag_t             t3;
  } row_t;

  fust_state_t         row_state [NUM_ROWS];
  row_t                rows      [NUM_ROWS];
  logic [IDX_W-1:0]    rr_ptr;
  logic [NUM_ROWS-1:0] free_vec;
  logic [NUM_ROWS-1:0] grant;
  logic                wb_hit;
  logic                dispatch_fire;
  row_t                new_row;
  logic                new_ready;

  function automatic tag_t snoop(tag_t t, logic hit, tag_t wtag);
    return (hit && (t == wtag)) ? tag_t'(TAG_NONE) : t;
  endfunction

  function automatic logic tags_clear(row_t r);
    return (r.t1 == '0) && (r.t2 == '0) && (r.t3 == '0);
  endfunction

  for (genvar g = 0; g < NUM_ROWS; g++) begin : g_flags
    assign free_vec[g]  = (row_state[g] == FREE);
    assign busy_vec[g]  = (row_state[g] != FREE);
    assign ready_vec[g] = (row_state[g] == READY);
  end

  assign full = ~|free_vec;

  always_comb begin
    alloc_idx = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_idx = IDX_W'(i);
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      occupancy = occupancy + CNT_W'(busy_vec[i]);
    end
  end

  rr_arbiter #(.N(NUM_ROWS), .IDX_W(IDX_W)) u_arb (
    .req   (ready_vec),
    .ptr   (rr_ptr),
    .valid (issue_valid),
    .grant (grant),
    .idx   (issue_idx)
  );

  assign issue_row = issue_valid ? rows[issue_idx].payload : '0;

  // Incoming tags that match this cycle's writeback are stored already cleared
  assign wb_hit        = wb_valid && (wb_tag != tag_t'(TAG_NONE));
  assign dispatch_fire = dispatch_en && !full;

  always_comb begin
    new_row.payload = dispatch_row;
    new_row.t1      = snoop(dispatch_t1, wb_hit, wb_tag);
    new_row.t2      = snoop(dispatch_t2, wb_hit, wb_tag);
    new_row.t3      = snoop(dispatch_t3, wb_hit, wb_tag);
    new_ready       = tags_clear(new_row);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr <= '0;
      for (int i = 0; i < NUM_ROWS; i++) begin
        row_state[i] <= FREE;
        rows[i]      <= '0;
      end
    end else begin
      if (issue_valid && issue_ready) rr_ptr <= issue_idx + IDX_W'(1);
      for (int i = 0; i < NUM_ROWS; i++) begin
        if (dispatch_fire && (alloc_idx == IDX_W'(i))) begin
          rows[i]      <= new_row;
          row_state[i] <= new_ready ? READY : WAIT;
        end else begin
          rows[i].t1 <= snoop(rows[i].t1, wb_hit, wb_tag);
          rows[i].t2 <= snoop(rows[i].t2, wb_hit, wb_tag);
          rows[i].t3 <= snoop(rows[i].t3, wb_hit, wb_tag);
          // WAIT promotes one edge after its last tag was cleared
          case (row_state[i])
            WAIT:    if (tags_clear(rows[i])) row_state[i] <= READY;
            READY:   if (grant[i] && issue_ready) row_state[i] <= ISSUED;
            ISSUED:  if (done_en && (done_idx == IDX_W'(i))) row_state[i] <= FREE;
            default: ;
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fust_bank.sv
`default_nettype none
// ============================================================================
// tb_fust_bank : directed + randomized bench against a row-level reference model
// Revision 1.0
// ============================================================================
module tb_fust_bank;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int TW = 2;
  localparam int RW = 32;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          dispatch_en = 1'b0;
  logic [RW-1:0] dispatch_row = '0;
  logic [TW-1:0] dispatch_t1 = '0, dispatch_t2 = '0, dispatch_t3 = '0;
  logic          full;
  logic [IW-1:0] alloc_idx;
  logic          wb_valid = 1'b0;
  logic [TW-1:0] wb_tag = '0;
  logic          issue_valid;
  logic          issue_ready = 1'b0;
  logic [IW-1:0] issue_idx;
  logic [RW-1:0] issue_row;
  logic          done_en = 1'b0;
  logic [IW-1:0] done_idx = '0;
  logic [N-1:0]  busy_vec, ready_vec;
  logic [IW:0]   occupancy;

  fust_bank #(.NUM_ROWS(N), .TAG_W(TW), .ROW_W(RW)) dut (
    .CLK(CLK), .nRST(nRST),
    .dispatch_en(dispatch_en), .dispatch_row(dispatch_row),
    .dispatch_t1(dispatch_t1), .dispatch_t2(dispatch_t2), .dispatch_t3(dispatch_t3),
    .full(full), .alloc_idx(alloc_idx),
    .wb_valid(wb_valid), .wb_tag(wb_tag),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_idx(issue_idx), .issue_row(issue_row),
    .done_en(done_en), .done_idx(done_idx),
    .busy_vec(busy_vec), .ready_vec(ready_vec), .occupancy(occupancy)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: 0 empty, 1 pending tags, 2 ready, 3 in the FU
  int          m_st  [N];
  int          m_tag [N][3];
  logic [31:0] m_pay [N];
  int          m_ptr;

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i] = 0; m_pay[i] = '0;
      for (int k = 0; k < 3; k++) m_tag[i][k] = 0;
    end
    m_ptr = 0;
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_st[i] != 0) c++;
    return c;
  endfunction

  function automatic int m_alloc();
    for (int i = 0; i < N; i++) if (m_st[i] == 0) return i;
    return 0;
  endfunction

  function automatic int m_pick();
    for (int k = 0; k < N; k++) if (m_st[(m_ptr + k) % N] == 2) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic check_outputs();
    int          p = m_pick();
    logic [3:0]  eb = '0, er = '0;
    for (int i = 0; i < N; i++) begin
      eb[i] = (m_st[i] != 0);
      er[i] = (m_st[i] == 2);
    end
    chk("full",      64'(full),        64'(m_count() == N));
    chk("occupancy", 64'(occupancy),   64'(m_count()));
    chk("alloc_idx", 64'(alloc_idx),   64'(m_alloc()));
    chk("busy_vec",  64'(busy_vec),    64'(eb));
    chk("ready_vec", 64'(ready_vec),   64'(er));
    chk("issue_vld", 64'(issue_valid), 64'(p >= 0));
    chk("issue_idx", 64'(issue_idx),   64'((p >= 0) ? p : 0));
    chk("issue_row", 64'(issue_row),   64'((p >= 0) ? m_pay[p] : 32'h0));
  endtask

  task automatic model_step();
    int nst [N];
    int ntg [N][3];
    int a     = m_alloc();
    int p     = m_pick();
    bit was_full = (m_count() == N);
    int wt    = (wb_valid && wb_tag != 0) ? int'(wb_tag) : -1;
    int din [3];
    nst = m_st;
    ntg = m_tag;
    for (int i = 0; i < N; i++) begin
      if (m_st[i] == 1 && m_tag[i][0] == 0 && m_tag[i][1] == 0 && m_tag[i][2] == 0) nst[i] = 2;
      for (int k = 0; k < 3; k++) if (m_tag[i][k] == wt) ntg[i][k] = 0;
    end
    if (p >= 0 && issue_ready) begin
      nst[p] = 3;
      m_ptr  = (p + 1) % N;
    end
    if (done_en && m_st[int'(done_idx)] == 3) nst[int'(done_idx)] = 0;
    if (dispatch_en && !was_full) begin
      din[0] = int'(dispatch_t1); din[1] = int'(dispatch_t2); din[2] = int'(dispatch_t3);
      for (int k = 0; k < 3; k++) ntg[a][k] = (din[k] == wt) ? 0 : din[k];
      nst[a]   = (ntg[a][0] == 0 && ntg[a][1] == 0 && ntg[a][2] == 0) ? 2 : 1;
      m_pay[a] = dispatch_row;
    end
    m_st  = nst;
    m_tag = ntg;
  endtask

  task automatic tick();
    @(negedge CLK);
    check_outputs();
    model_step();
    @(posedge CLK);
    #1;
    dispatch_en = 1'b0; wb_valid = 1'b0; issue_ready = 1'b0; done_en = 1'b0;
  endtask

  task automatic disp(input logic [31:0] pay, input int a, input int b, input int c);
    dispatch_en = 1'b1; dispatch_row = pay;
    dispatch_t1 = TW'(a); dispatch_t2 = TW'(b); dispatch_t3 = TW'(c);
  endtask

  task automatic wb(input int t);
    wb_valid = 1'b1; wb_tag = TW'(t);
  endtask

  task automatic done(input int i);
    done_en = 1'b1; done_idx = IW'(i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    m_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_full",  64'(full),        64'(0));
    chk("rst_valid", 64'(issue_valid), 64'(0));
    chk("rst_occ",   64'(occupancy),   64'(0));
    nRST = 1'b1;
    tick();

    // minimum latency, issue, completion
    disp(32'hA5A5_0001, 0, 0, 0); tick();
    chk("lat_valid", 64'(issue_valid), 64'(1));
    chk("lat_idx",   64'(issue_idx),   64'(0));
    chk("lat_row",   64'(issue_row),   64'(32'hA5A5_0001));
    issue_ready = 1'b1; tick();
    chk("iss_busy",  64'(busy_vec),  64'(4'b0001));
    chk("iss_ready", 64'(ready_vec), 64'(4'b0000));
    done(0); tick();
    chk("done_busy", 64'(busy_vec), 64'(4'b0000));

    // dependency tracking
    disp(32'h1111_0002, 2, 0, 3); tick();
    chk("wait_rdy", 64'(ready_vec), 64'(4'b0000));
    wb(2); tick();
    chk("wb2_rdy", 64'(ready_vec), 64'(4'b0000));
    wb(3); tick();
    chk("wb3_same", 64'(ready_vec), 64'(4'b0000));
    tick();
    chk("wb3_next", 64'(ready_vec), 64'(4'b0001));
    issue_ready = 1'b1; tick();
    done(0); tick();

    // dispatch/writeback bypass
    disp(32'h2222_0003, 0, 1, 0); wb(1); tick();
    chk("byp_ready", 64'(ready_vec),   64'(4'b0001));
    chk("byp_valid", 64'(issue_valid), 64'(1));
    issue_ready = 1'b1; tick();
    done(0); tick();

    // fill, drop when full, drain (pointer sits at 1 here)
    for (int k = 0; k < 4; k++) begin
      disp(32'h3333_0000 + 32'(k), 0, 0, 0); tick();
    end
    chk("fill_full", 64'(full),      64'(1));
    chk("fill_occ",  64'(occupancy), 64'(4));
    disp(32'hDEAD_BEEF, 0, 0, 0); tick();
    chk("drop_occ", 64'(occupancy), 64'(4));
    for (int k = 0; k < 4; k++) begin
      chk("drain_idx", 64'(issue_idx), 64'((1 + k) % 4));
      chk("drain_row", 64'(issue_row), 64'(32'h3333_0000 + 32'((1 + k) % 4)));
      issue_ready = 1'b1; tick();
    end
    done(2); disp(32'hBAD0_0001, 0, 0, 0); tick();
    chk("dfull_full", 64'(full),      64'(0));
    chk("dfull_occ",  64'(occupancy), 64'(3));
    chk("dfull_busy", 64'(busy_vec),  64'(4'b1011));
    done(0); tick();
    done(1); tick();
    done(3); tick();

    // walk the pointer to 0, then check in-order issue and wrap
    for (int k = 0; k < 3; k++) begin
      disp(32'h4444_0000 + 32'(k), 1, 0, 0); tick();
    end
    disp(32'h4444_0003, 0, 0, 0); tick();
    chk("r3_only", 64'(ready_vec), 64'(4'b1000));
    issue_ready = 1'b1; tick();
    done(3); wb(1); tick();
    disp(32'h4444_0013, 0, 0, 0); tick();
    chk("all_rdy", 64'(ready_vec), 64'(4'b1111));
    for (int k = 0; k < 4; k++) begin
      chk("order", 64'(issue_idx), 64'(k));
      issue_ready = 1'b1; tick();
    end
    done(0); tick();
    done(2); tick();
    disp(32'h5555_0000, 0, 0, 0); tick();
    disp(32'h5555_0002, 0, 0, 0); tick();
    chk("wrap_rdy",  64'(ready_vec), 64'(4'b0101));
    chk("wrap_pick", 64'(issue_idx), 64'(0));
    chk("wrap_row",  64'(issue_row), 64'(32'h5555_0000));
    issue_ready = 1'b1; tick();
    issue_ready = 1'b1; tick();
    for (int k = 0; k < 4; k++) begin
      done(k); tick();
    end

    // asynchronous reset mid-stream
    for (int k = 0; k < 3; k++) begin
      disp(32'h6666_0000 + 32'(k), 0, k, 0); tick();
    end
    chk("pre_rst_busy", 64'(busy_vec), 64'(4'b0111));
    #2;
    nRST = 1'b0;
    #1;
    chk("arst_busy",  64'(busy_vec),    64'(0));
    chk("arst_ready", 64'(ready_vec),   64'(0));
    chk("arst_full",  64'(full),        64'(0));
    chk("arst_occ",   64'(occupancy),   64'(0));
    chk("arst_valid", 64'(issue_valid), 64'(0));
    chk("arst_alloc", 64'(alloc_idx),   64'(0));
    chk("arst_idx",   64'(issue_idx),   64'(0));
    chk("arst_row",   64'(issue_row),   64'(0));
    m_reset();
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    done(0); tick();
    chk("post_rst_done", 64'(busy_vec), 64'(0));

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      dispatch_en  = 1'($urandom_range(0, 1));
      dispatch_row = $urandom;
      dispatch_t1  = ($urandom_range(0, 2) == 0) ? TW'($urandom_range(0, 3)) : '0;
      dispatch_t2  = ($urandom_range(0, 2) == 0) ? TW'($urandom_range(0, 3)) : '0;
      dispatch_t3  = ($urandom_range(0, 2) == 0) ? TW'($urandom_range(0, 3)) : '0;
      wb_valid     = ($urandom_range(0, 2) == 0);
      wb_tag       = TW'($urandom_range(0, 3));
      issue_ready  = 1'($urandom_range(0, 1));
      done_en      = 1'($urandom_range(0, 1));
      done_idx     = IW'($urandom_range(0, N - 1));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fust_bank.md
Name: fust_bank

Overview:
- Parametrised multi-row functional-unit status table; the next generation of the single-row FUST in the scoreboard.
- Holds up to NUM_ROWS dispatched ops for one functional-unit class.
- Tracks three source-dependency tags per row and clears them on writeback broadcasts.
- Selects one ready row per cycle for issue (round-robin) and frees the row when the FU reports completion.

Parameters:
- NUM_ROWS, 4, number of table rows (power of 2, >=2); IDX_W = $clog2(NUM_ROWS).
- TAG_W, 2, width of a dependency tag; tag value 0 = no dependency.
- ROW_W, 32, width of the opaque row payload (packed fust row struct).

Ports:
- CLK  in  1  clock
- nRST  in  1  reset; asynchronous, active-low
- dispatch_en  in  1  write a new row this cycle
- dispatch_row  in  ROW_W  payload to store
- dispatch_t1, dispatch_t2, dispatch_t3  in  TAG_W each  producing-FU tags for the three sources
- full  out  1  no FREE row
- alloc_idx  out  IDX_W  row that a dispatch this cycle will occupy (lowest-index FREE row)
- wb_valid  in  1  writeback broadcast valid
- wb_tag  in  TAG_W  tag being written back
- issue_valid  out  1  at least one READY row
- issue_ready  in  1  FU accepts the offered row
- issue_idx  out  IDX_W  offered row index
- issue_row  out  ROW_W  offered row payload
- done_en  in  1  FU finished an op
- done_idx  in  IDX_W  row whose op finished
- busy_vec  out  NUM_ROWS  per-row occupied (state != FREE)
- ready_vec  out  NUM_ROWS  per-row READY
- occupancy  out  IDX_W+1  count of non-FREE rows

Behaviour:
- Per-row state: FREE, WAIT, READY, ISSUED; each row stores its payload and t1/t2/t3.
- Reset: all rows FREE, tags 0, payload 0, round-robin pointer 0. Resulting outputs: full=0, issue_valid=0, busy_vec=0, ready_vec=0, occupancy=0, alloc_idx=0, issue_idx=0, issue_row=0.
- Reset asserted mid-operation discards all rows immediately.
- Dispatch: if dispatch_en && !full, row alloc_idx loads at the clock edge. It goes to READY if all stored tags are 0, else WAIT.
- Dispatch while full is ignored: no state change, nothing overwritten.
- Writeback: if wb_valid and wb_tag != 0, every stored tag equal to wb_tag becomes 0 at the edge.
- Same-cycle dispatch and writeback: an incoming dispatch tag equal to wb_tag is stored as 0 (bypass).
- wb_tag == 0 has no effect.
- WAIT -> READY on the edge after its last nonzero tag clears, so ready_vec rises one cycle after that writeback.
- Issue selection (combinational from registered state): scan from the round-robin pointer upward, wrapping, for the first READY row.
  - issue_valid = any READY; issue_idx and issue_row show the selected row.
  - When issue_valid=0, issue_idx and issue_row hold 0.
- Handshake: on issue_valid && issue_ready, the selected row goes READY -> ISSUED and the pointer becomes issue_idx+1 mod NUM_ROWS.
- Offers may change between cycles while not accepted; there is no hold requirement.
- Completion: done_en with row done_idx in ISSUED -> FREE at the edge. done_en on a non-ISSUED row is ignored.
- Simultaneous done and dispatch: a row freed this cycle is not visible to alloc_idx or full until the next cycle.
  - When full=1 and done_en arrives, a same-cycle dispatch is still dropped.
- Simultaneous issue and done on different rows: both take effect.
- Simultaneous issue and writeback: the writeback does not affect the row being issued, since READY rows have all tags 0.
- Minimum latency: dispatch at cycle N with zero tags -> issue_valid at N+1.
- full, alloc_idx, busy_vec, ready_vec and occupancy derive from registered state only.
- No combinational path from any input to any output except issue_ready, which affects nothing combinationally.

Decomposition:
- Shared package (datapath_pkg) holds:
  - the fust_state_t enum (FREE/WAIT/READY/ISSUED)
  - a parametrised-width fust_tag_t
  - the fust row struct carrying payload and t1/t2/t3
  - the constant TAG_NONE = 0
- One natural sub-module: rr_arbiter (NUM_ROWS request vector plus pointer -> one-hot grant and index), reusable by other issue queues.

Test Plan:
- Reset, then dispatch a payload of 32'hA5A5_0001 with all tags 0 at cycle 1 -> cycle 2: issue_valid=1, issue_idx=0, issue_row=32'hA5A5_0001. Assert issue_ready -> busy_vec=4'b0001, ready_vec=0. Then done_en with idx 0 -> busy_vec=0.
- Dispatch with t1=2, t3=3 -> row WAIT. Writeback tag 2 -> still WAIT. Writeback tag 3 -> ready_vec bit set on the following cycle.
- Dispatch with t2=1 in the same cycle as wb_valid, wb_tag=1 -> row stored READY, and issue_valid rises the next cycle.
- Fill all 4 rows -> full=1, occupancy=4. A 5th dispatch is dropped and row contents are unchanged. Same-cycle done_en plus dispatch -> still dropped; full=0 the following cycle.
- Rows 0-3 all READY with issue_ready held high -> issue order 0,1,2,3. Then re-dispatch into rows 0 and 2 -> next issue picks row 0 after the pointer wraps from 3.
- Assert nRST low mid-stream with 3 rows busy -> all outputs return to reset values asynchronously. A done_en after release is ignored.
